rob_ctrl: RTL and testbench

//  Sequencer for the reorder buffer: owns head/tail pointers over ROB_DEPTH line slots,

---
 rtl/rob_ctrl_pkg.sv | 14 +
 rtl/rob_ptr.sv | 22 ++
 rtl/rob_ctrl.sv | 87 ++++++++
 tb/tb_rob_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared sizing defaults and the per-cycle handshake record for the reorder-buffer sequencer.
// Imported by rob_ptr and rob_ctrl.
package rob_ctrl_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int ROB_ID_W_DEF  = 4;

  typedef struct packed {
    logic alloc;
    logic wb;
    logic commit;
  } rob_fire_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit pointer (ID_W index bits plus one lap bit) with clear and increment.
// The lap bit toggles naturally when the index rolls over from ROB_DEPTH-1 to 0.
module rob_ptr
  import rob_ctrl_pkg::*;
#(
  parameter int ID_W = ROB_ID_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [ID_W:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencer: in-order allocation, out-of-order writeback routing and
// in-order commit of the head slot. Line storage is external and holds no pointer state.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int ID_W      = ROB_ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [ID_W-1:0]      alloc_id,
  input  logic                 wb_valid,
  input  logic [ID_W-1:0]      wb_id,
  output logic                 wb_accept,
  input  logic [ROB_DEPTH-1:0] line_done,
  output logic [ROB_DEPTH-1:0] line_write_en,
  output logic [ROB_DEPTH-1:0] line_wb_sel,
  output logic                 commit_valid,
  output logic [ID_W-1:0]      commit_id,
  input  logic                 commit_ready,
  output logic [ID_W:0]        rob_count,
  output logic                 rob_empty,
  output logic                 rob_full
);

  logic [ID_W:0]   head_ptr;
  logic [ID_W:0]   tail_ptr;
  logic [ID_W-1:0] head_idx;
  logic [ID_W-1:0] tail_idx;
  logic [ID_W-1:0] wb_off;
  logic            wb_occupied;
  rob_fire_t       fire;

  assign head_idx = head_ptr[ID_W-1:0];
  assign tail_idx = tail_ptr[ID_W-1:0];

  // The lap bit makes tail - head an exact occupancy count in 0..ROB_DEPTH.
  assign rob_count = tail_ptr - head_ptr;
  assign rob_empty = (head_ptr == tail_ptr);
  assign rob_full  = (head_idx == tail_idx) && (head_ptr[ID_W] != tail_ptr[ID_W]);

  // A slot is live iff its distance from head (modulo depth) is below the count.
  assign wb_off      = wb_id - head_idx;
  assign wb_occupied = ({1'b0, wb_off} < rob_count);

  assign alloc_ready  = !rob_full && !flush;
  assign alloc_id     = tail_idx;
  assign wb_accept    = wb_valid && wb_occupied && !flush;
  assign commit_valid = !rob_empty && line_done[head_idx] && !flush;
  assign commit_id    = head_idx;

  assign fire.alloc  = alloc_valid && alloc_ready;
  assign fire.wb     = wb_accept;
  assign fire.commit = commit_valid && commit_ready;

  // Alloc targets a free slot and writeback an occupied one, so the two never overlap.
  always_comb begin
    line_write_en = '0;
    line_wb_sel   = '0;
    if (fire.alloc)
      line_write_en[tail_idx] = 1'b1;
    if (fire.wb) begin
      line_write_en[wb_id] = 1'b1;
      line_wb_sel[wb_id]   = 1'b1;
    end
  end

  rob_ptr #(.ID_W(ID_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (fire.commit),
    .ptr (head_ptr)
  );

  rob_ptr #(.ID_W(ID_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (fire.alloc),
    .ptr (tail_ptr)
  );

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: directed scenarios then random traffic, checked against a
// queue-based model of the in-flight slots plus a behavioural model of the line done flags.
module tb_rob_ctrl;

  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_id;
  logic          wb_valid;
  logic [IW-1:0] wb_id;
  logic          wb_accept;
  logic [D-1:0]  line_done;
  logic [D-1:0]  line_write_en;
  logic [D-1:0]  line_wb_sel;
  logic          commit_valid;
  logic [IW-1:0] commit_id;
  logic          commit_ready;
  logic [IW:0]   rob_count;
  logic          rob_empty;
  logic          rob_full;

  rob_ctrl #(.ROB_DEPTH(D), .ID_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_id      (alloc_id),
    .wb_valid      (wb_valid),
    .wb_id         (wb_id),
    .wb_accept     (wb_accept),
    .line_done     (line_done),
    .line_write_en (line_write_en),
    .line_wb_sel   (line_wb_sel),
    .commit_valid  (commit_valid),
    .commit_id     (commit_id),
    .commit_ready  (commit_ready),
    .rob_count     (rob_count),
    .rob_empty     (rob_empty),
    .rob_full      (rob_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: slot ids in flight, oldest first, and the head slot index.
  int q[$];
  int m_head = 0;
  int m_tail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_tail = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model across the edge.
  task automatic step(input bit av, input bit wv, input int wi, input bit cr,
                      input bit fl, input bit r);
    bit           occ;
    bit           e_ar;
    bit           e_wa;
    bit           e_cv;
    logic [D-1:0] e_en;
    logic [D-1:0] e_sel;
    int           cnt;
    alloc_valid  = av;
    wb_valid     = wv;
    wb_id        = wi[IW-1:0];
    commit_ready = cr;
    flush        = fl;
    rst          = r;
    #2;
    cnt = q.size();
    occ = 1'b0;
    foreach (q[k]) if (q[k] == wi) occ = 1'b1;
    e_ar = !fl && (cnt < D);
    e_wa = wv && occ && !fl;
    e_cv = 1'b0;
    if (!fl && cnt > 0) e_cv = line_done[q[0]];
    e_en  = '0;
    e_sel = '0;
    if (av && e_ar) e_en[m_tail] = 1'b1;
    if (e_wa) begin
      e_en[wi]  = 1'b1;
      e_sel[wi] = 1'b1;
    end
    check("alloc_ready", 32'(alloc_ready), 32'(e_ar));
    check("alloc_id", 32'(alloc_id), 32'(m_tail));
    check("wb_accept", 32'(wb_accept), 32'(e_wa));
    check("line_write_en", 32'(line_write_en), 32'(e_en));
    check("line_wb_sel", 32'(line_wb_sel), 32'(e_sel));
    check("commit_valid", 32'(commit_valid), 32'(e_cv));
    check("commit_id", 32'(commit_id), 32'(m_head));
    check("rob_count", 32'(rob_count), 32'(cnt));
    check("rob_empty", 32'(rob_empty), 32'(cnt == 0));
    check("rob_full", 32'(rob_full), 32'(cnt == D));
    @(posedge clk);
    #1;
    if (r || fl) begin
      model_reset();
    end else begin
      if (e_cv && cr) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % D;
      end
      if (av && e_ar) begin
        q.push_back(m_tail);
        line_done[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % D;
      end
      if (e_wa) line_done[wi] = 1'b1;
    end
  endtask

  initial begin
    int wi;
    rst          = 1'b1;
    flush        = 1'b0;
    alloc_valid  = 1'b0;
    wb_valid     = 1'b0;
    wb_id        = '0;
    commit_ready = 1'b0;
    line_done    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state
    step(0, 0, 0, 0, 0, 0);

    // Fill to full, then one extra request that must be refused
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 0, 0);
    check("fill_full", 32'(rob_full), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    check("fill_count_hold", 32'(rob_count), 32'(D));
    step(0, 0, 0, 0, 1, 0);

    // Out-of-order writeback and commit of the head
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 9, 0, 0, 0);
    // Head is done: stall three cycles, then commit together with an alloc
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("stall_cv_held", 32'(commit_valid), 32'd1);
    end
    step(1, 0, 0, 1, 0, 0);
    check("concurrent_count", 32'(rob_count), 32'd4);
    check("concurrent_head", 32'(commit_id), 32'd1);
    check("concurrent_tail", 32'(alloc_id), 32'd5);
    step(0, 0, 0, 0, 1, 0);

    // Walk head and tail to 14, then wrap
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, i, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
    end
    check("wrap_start", 32'(alloc_id), 32'd14);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    check("wrap_count", 32'(rob_count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 1, (14 + i) % D, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    check("wrap_empty", 32'(rob_empty), 32'd1);
    check("wrap_head", 32'(commit_id), 32'd2);
    check("wrap_tail", 32'(alloc_id), 32'd2);

    // Flush with 7 live entries and concurrent requests
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    step(1, 1, 4, 1, 1, 0);
    check("flush_count", 32'(rob_count), 32'd0);
    check("flush_alloc_id", 32'(alloc_id), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1);
    check("rst_flush_empty", 32'(rob_empty), 32'd1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if (q.size() > 0 && ($urandom % 3) != 0)
        wi = q[$urandom_range(0, q.size() - 1)];
      else
        wi = $urandom_range(0, D - 1);
      step(($urandom % 2) == 0, ($urandom % 2) == 0, wi, ($urandom % 10) < 7,
           ($urandom % 60) == 0, ($urandom % 300) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
